// File: rtl/ahb_ndp_result_port.sv
// AHB-Lite slave for the NDP core: control/status registers, done-triggered result
// snapshot, and a word-addressed readback window over the packed result bus.
module ahb_ndp_result_port #(
   parameter int ELEM_W    = 16,
   parameter int NUM_ELEM  = 1024,
   parameter int ADDR_W    = 16,
   parameter int WIN_BASE  = 'h100,
   parameter int SNAPSHOT  = 1,
   parameter int READ_WAIT = 1
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic                         HSEL,
   input  logic [ADDR_W-1:0]            HADDR,
   input  logic [1:0]                   HTRANS,
   input  logic                         HWRITE,
   input  logic [2:0]                   HSIZE,
   input  logic [31:0]                  HWDATA,
   input  logic                         HREADY,
   output logic                         HREADYOUT,
   output logic                         HRESP,
   output logic [31:0]                  HRDATA,
   output logic                         core_reset_o,
   output logic                         core_start_o,
   input  logic                         core_done_i,
   input  logic [NUM_ELEM*ELEM_W-1:0]   result_i
);
   localparam int EPW    = 32 / ELEM_W;
   localparam int NWORDS = (NUM_ELEM + EPW - 1) / EPW;
   localparam int RES_W  = NUM_ELEM * ELEM_W;
   localparam int PAD_W  = NWORDS * 32;
   localparam int WIDX_W = ADDR_W - 2;
   localparam logic [ADDR_W-1:0] WIN_BASE_A = ADDR_W'(WIN_BASE);
   localparam logic [1:0]        RW         = 2'(READ_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
   state_t state_q, state_d;

   logic [1:0]        cnt_q;
   logic              vld_p1, wr_p1, win_p1;
   logic [1:0]        reg_sel_p1;
   logic [WIDX_W-1:0] widx_p1;
   logic              core_done_q, busy_q, done_q, snap_valid_q, err_q;
   logic [31:0]       snap_cnt_q;
   logic [RES_W-1:0]  snap;

   // Address phase (p0): decode legality of the presented transfer
   logic              acc_p0, legal_p0, win_rd_p0, in_win_p0, is_reg_p0;
   logic [ADDR_W-1:0] win_off_p0;

   assign acc_p0     = HSEL & HTRANS[1] & HREADY;
   assign win_off_p0 = HADDR - WIN_BASE_A;
   assign in_win_p0  = (HADDR >= WIN_BASE_A) && (32'(win_off_p0[ADDR_W-1:2]) < 32'(NWORDS));
   assign is_reg_p0  = HADDR < ADDR_W'('h10);
   assign win_rd_p0  = !HWRITE && in_win_p0;
   assign legal_p0   = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) &&
                       (HWRITE ? (HADDR == ADDR_W'(0) || HADDR == ADDR_W'(4)) : (is_reg_p0 || in_win_p0));

   // Data phase (p1): registered address/control
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)    vld_p1 <= 1'b0;
      else if (HREADY) vld_p1 <= acc_p0 & legal_p0;
   end

   always_ff @(posedge HCLK) begin
      if (HREADY) begin
         wr_p1      <= HWRITE;
         win_p1     <= win_rd_p0;
         reg_sel_p1 <= HADDR[3:2];
         widx_p1    <= win_off_p0[ADDR_W-1:2];
      end
   end

   logic [RES_W-1:0] src;
   logic [PAD_W-1:0] src_pad;
   logic [31:0]      win_word, win_late, reg_word;

   assign src = (SNAPSHOT != 0) ? snap : result_i;
   always_comb begin
      src_pad            = '0;
      src_pad[RES_W-1:0] = src;
   end
   assign win_word = src_pad[{widx_p1, 5'b00000} +: 32];

   // Data phase (p2..): window read mux pipeline, one stage per wait state
   generate
      if (READ_WAIT > 0) begin : g_pipe
         logic [31:0] rd_pipe_p2 [READ_WAIT];
         always_ff @(posedge HCLK) begin
            rd_pipe_p2[0] <= win_word;
            for (int i = 1; i < READ_WAIT; i++) rd_pipe_p2[i] <= rd_pipe_p2[i-1];
         end
         assign win_late = rd_pipe_p2[READ_WAIT-1];
      end else begin : g_nopipe
         assign win_late = win_word;
      end
   endgenerate

   always_comb begin
      case (reg_sel_p1)
         2'd0:    reg_word = {31'b0, core_reset_o};
         2'd1:    reg_word = {28'b0, err_q, snap_valid_q, done_q, busy_q};
         2'd2:    reg_word = snap_cnt_q;
         default: reg_word = {8'h00, 8'(ELEM_W), 16'(NUM_ELEM)};
      endcase
   end

   // Control side effects of a completed data-phase write
   logic wr_ctrl, wr_stat, done_rise, start_req, start_ok, start_bad;
   assign wr_ctrl   = (state_q == S_IDLE) && vld_p1 && wr_p1 && (reg_sel_p1 == 2'd0);
   assign wr_stat   = (state_q == S_IDLE) && vld_p1 && wr_p1 && (reg_sel_p1 == 2'd1);
   assign done_rise = core_done_i & ~core_done_q;
   assign start_req = wr_ctrl & HWDATA[1];
   assign start_ok  = start_req & ~(busy_q & ~done_rise) & ~core_reset_o & ~HWDATA[0];
   assign start_bad = start_req & ~start_ok;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         core_done_q  <= 1'b0;
         core_start_o <= 1'b0;
         core_reset_o <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         snap_valid_q <= 1'b0;
         err_q        <= 1'b0;
         snap_cnt_q   <= '0;
      end else begin
         core_done_q  <= core_done_i;
         core_start_o <= start_ok;
         if (done_rise) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (SNAPSHOT != 0) begin
               snap_valid_q <= 1'b1;
               snap_cnt_q   <= snap_cnt_q + 32'd1;
            end
         end
         if (start_ok) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
         end
         if (wr_ctrl) begin
            core_reset_o <= HWDATA[0];
            if (HWDATA[0]) begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         end
         if (state_q == S_ERR1 || start_bad) err_q <= 1'b1;
         else if (wr_stat && HWDATA[3])     err_q <= 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                         snap <= '0;
      else if (SNAPSHOT != 0 && done_rise)  snap <= result_i;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == S_WAIT && cnt_q != RW) ? cnt_q + 2'd1 : 2'd0;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      if (state_q == S_ERR1)                         state_d = S_ERR2;
      else if (state_q == S_WAIT && cnt_q != RW)     state_d = S_WAIT;
      else if (acc_p0 && !legal_p0)                  state_d = S_ERR1;
      else if (acc_p0 && win_rd_p0 && READ_WAIT > 0) state_d = S_WAIT;
   end

   always_comb begin
      HREADYOUT = !(state_q == S_ERR1 || (state_q == S_WAIT && cnt_q != RW));
      HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
      HRDATA    = 32'h0;
      if (state_q == S_WAIT && cnt_q == RW)
         HRDATA = win_late;
      else if (state_q == S_IDLE && vld_p1 && !wr_p1)
         HRDATA = win_p1 ? win_word : reg_word;
   end

   logic unused_bits;
   assign unused_bits = ^{HTRANS[0], HWDATA[31:4], HWDATA[2], win_off_p0[1:0]};
endmodule

// File: tb/tb_ahb_ndp_result_port.sv
// Directed bench for ahb_ndp_result_port: default instance plus a narrow-element,
// zero-wait instance sharing one AHB master.
module tb_ahb_ndp_result_port;
   localparam logic [2:0] SZW = 3'b010;

   logic        clk = 1'b0;
   logic        hresetn;
   logic        hsel, hwrite, use_b;
   logic [15:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready, hresp;
   logic [31:0] hrdata;

   logic        hreadyout_a, hresp_a, core_reset_a, core_start_a, done_a;
   logic [31:0] hrdata_a;
   logic [16383:0] result_a;
   logic        hreadyout_b, hresp_b, core_reset_b, core_start_b, done_b;
   logic [31:0] hrdata_b;
   logic [47:0] result_b;

   int n_tests = 0;
   int n_fail  = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;

   assign hready = use_b ? hreadyout_b : hreadyout_a;
   assign hresp  = use_b ? hresp_b     : hresp_a;
   assign hrdata = use_b ? hrdata_b    : hrdata_a;

   ahb_ndp_result_port u_dut_a (
      .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel & ~use_b), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hreadyout_a), .HRESP(hresp_a), .HRDATA(hrdata_a),
      .core_reset_o(core_reset_a), .core_start_o(core_start_a),
      .core_done_i(done_a), .result_i(result_a));

   ahb_ndp_result_port #(.ELEM_W(8), .NUM_ELEM(6), .READ_WAIT(0)) u_dut_b (
      .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel & use_b), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hreadyout_b), .HRESP(hresp_b), .HRDATA(hrdata_b),
      .core_reset_o(core_reset_b), .core_start_o(core_start_b),
      .core_done_i(done_b), .result_i(result_b));

   always @(posedge clk) if (core_start_a === 1'b1) start_cnt <= start_cnt + 1;

   typedef struct {
      logic        use_b;
      logic        wr;
      logic [15:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_resp;
      int          exp_waits;
   } vec_t;

   vec_t tbl [36];

   function automatic vec_t mk(input logic b, input logic wr, input logic [15:0] a, input logic [2:0] sz,
                               input logic [31:0] wd, input logic [31:0] er, input logic eresp, input int ew);
      vec_t v;
      v.use_b = b; v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd;
      v.exp_rd = er; v.exp_resp = eresp; v.exp_waits = ew;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%08h, want 'h%08h", nm, act, exp);
      end
   endtask

   task automatic xfer(input logic wr, input logic [15:0] addr, input logic [2:0] size, input logic [31:0] wd,
                       output logic [31:0] rd, output logic resp0, output logic resp, output int waits);
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wd;
      waits = 0; resp0 = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (cyc == 0) resp0 = hresp;
         if (hready) break;
         waits++;
      end
      rd = hrdata; resp = hresp;
   endtask

   task automatic run_range(input int lo, input int hi);
      logic [31:0] rd;
      logic r0, r1;
      int w;
      for (int i = lo; i <= hi; i++) begin
         use_b = tbl[i].use_b;
         xfer(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, rd, r0, r1, w);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_resp", i), {30'b0, r0, r1}, {30'b0, tbl[i].exp_resp, tbl[i].exp_resp});
         chk($sformatf("vec%0d_waits", i), 32'(w), 32'(tbl[i].exp_waits));
      end
   endtask

   task automatic wr_rd(input logic [15:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      logic r0, r1;
      int w;
      xfer(1'b1, addr, SZW, wd, rd, r0, r1, w);
   endtask

   task automatic rd_chk(input string nm, input logic [15:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic r0, r1;
      int w;
      xfer(1'b0, addr, SZW, 32'h0, rd, r0, r1, w);
      chk(nm, rd, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int p0;
      // after reset, DUT A
      tbl[0]  = mk(0, 0, 16'h000, SZW, 0, 32'h1, 0, 0);
      tbl[1]  = mk(0, 0, 16'h004, SZW, 0, 32'h0, 0, 0);
      tbl[2]  = mk(0, 0, 16'h008, SZW, 0, 32'h0, 0, 0);
      tbl[3]  = mk(0, 0, 16'h00C, SZW, 0, 32'h0010_0400, 0, 0);
      tbl[4]  = mk(0, 1, 16'h000, SZW, 0, 32'h0, 0, 0);
      tbl[5]  = mk(0, 0, 16'h000, SZW, 0, 32'h0, 0, 0);
      // after snapshot, DUT A
      tbl[6]  = mk(0, 0, 16'h100, SZW, 0, 32'hBC00_3C00, 0, 1);
      tbl[7]  = mk(0, 0, 16'h004, SZW, 0, 32'h6, 0, 0);
      tbl[8]  = mk(0, 0, 16'h008, SZW, 0, 32'h1, 0, 0);
      tbl[9]  = mk(0, 0, 16'h8FC, SZW, 0, 32'hABCD_1234, 0, 1);
      tbl[10] = mk(0, 0, 16'h900, SZW, 0, 32'h0, 1, 1);
      tbl[11] = mk(0, 0, 16'h004, SZW, 0, 32'hE, 0, 0);
      tbl[12] = mk(0, 0, 16'h000, 3'b001, 0, 32'h0, 1, 1);
      tbl[13] = mk(0, 1, 16'h008, SZW, 32'h5, 32'h0, 1, 1);
      tbl[14] = mk(0, 0, 16'h002, SZW, 0, 32'h0, 1, 1);
      tbl[15] = mk(0, 0, 16'h010, SZW, 0, 32'h0, 1, 1);
      tbl[16] = mk(0, 1, 16'h000, 3'b001, 32'h2, 32'h0, 1, 1);
      tbl[17] = mk(0, 1, 16'h004, SZW, 32'h8, 32'h0, 0, 0);
      tbl[18] = mk(0, 0, 16'h004, SZW, 0, 32'h6, 0, 0);
      tbl[19] = mk(0, 0, 16'h008, SZW, 0, 32'h1, 0, 0);
      // DUT B: 8-bit elements, 6 of them, zero wait
      tbl[20] = mk(1, 0, 16'h100, SZW, 0, 32'h0403_0201, 0, 0);
      tbl[21] = mk(1, 0, 16'h104, SZW, 0, 32'h0000_0605, 0, 0);
      tbl[22] = mk(1, 0, 16'h108, SZW, 0, 32'h0, 1, 1);
      tbl[23] = mk(1, 0, 16'h00C, SZW, 0, 32'h0008_0006, 0, 0);
      tbl[24] = mk(1, 0, 16'h004, SZW, 0, 32'hE, 0, 0);
      tbl[25] = mk(1, 0, 16'h008, SZW, 0, 32'h1, 0, 0);
      // after mid-wait reset, DUT A
      tbl[26] = mk(0, 0, 16'h000, SZW, 0, 32'h1, 0, 0);
      tbl[27] = mk(0, 0, 16'h004, SZW, 0, 32'h0, 0, 0);
      tbl[28] = mk(0, 0, 16'h008, SZW, 0, 32'h0, 0, 0);
      tbl[29] = mk(0, 0, 16'h100, SZW, 0, 32'h0, 0, 1);
      // core_reset clears busy
      tbl[30] = mk(0, 1, 16'h000, SZW, 32'h0, 32'h0, 0, 0);
      tbl[31] = mk(0, 1, 16'h000, SZW, 32'h2, 32'h0, 0, 0);
      tbl[32] = mk(0, 0, 16'h004, SZW, 0, 32'h1, 0, 0);
      tbl[33] = mk(0, 1, 16'h000, SZW, 32'h1, 32'h0, 0, 0);
      tbl[34] = mk(0, 0, 16'h004, SZW, 0, 32'h0, 0, 0);
      tbl[35] = mk(0, 0, 16'h000, SZW, 0, 32'h1, 0, 0);

      hresetn = 1'b0; use_b = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0;
      hwrite = 1'b0; hsize = SZW; hwdata = '0; done_a = 1'b0; done_b = 1'b0;
      result_a = '0;
      result_a[0*16 +: 16]    = 16'h3C00;
      result_a[1*16 +: 16]    = 16'hBC00;
      result_a[10*16 +: 16]   = 16'hAAAA;
      result_a[11*16 +: 16]   = 16'hBBBB;
      result_a[1022*16 +: 16] = 16'h1234;
      result_a[1023*16 +: 16] = 16'hABCD;
      result_b = 48'h06_05_04_03_02_01;

      repeat (3) @(negedge clk);
      chk("rst_hreadyout", {31'b0, hreadyout_a}, 32'h1);
      chk("rst_hresp", {31'b0, hresp_a}, 32'h0);
      chk("rst_hrdata", hrdata_a, 32'h0);
      chk("rst_core_reset", {31'b0, core_reset_a}, 32'h1);
      chk("rst_core_start", {31'b0, core_start_a}, 32'h0);
      hresetn = 1'b1;

      run_range(0, 5);
      chk("ctrl_core_reset_low", {31'b0, core_reset_a}, 32'h0);

      p0 = start_cnt;
      wr_rd(16'h000, 32'h2);
      repeat (3) @(negedge clk);
      chk("start_one_pulse", 32'(start_cnt - p0), 32'h1);
      rd_chk("start_status_busy", 16'h004, 32'h1);
      wr_rd(16'h000, 32'h2);
      repeat (3) @(negedge clk);
      chk("start_busy_no_pulse", 32'(start_cnt - p0), 32'h1);
      rd_chk("start_status_err", 16'h004, 32'h9);
      wr_rd(16'h004, 32'h8);
      rd_chk("status_w1c", 16'h004, 32'h1);

      @(negedge clk); done_a = 1'b1;
      repeat (2) @(negedge clk);
      result_a[31:0] = 32'hFFFF_0000;
      done_a = 1'b0;

      run_range(6, 19);
      chk("err_write_no_pulse", 32'(start_cnt - p0), 32'h1);

      // back-to-back NONSEQ: CTRL, window word 5, STATUS
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = SZW; haddr = 16'h000;
      @(negedge clk);
      chk("b2b_ctrl_ready", {31'b0, hready}, 32'h1);
      chk("b2b_ctrl_data", hrdata, 32'h0);
      haddr = 16'h114;
      @(negedge clk);
      chk("b2b_win_wait", {31'b0, hready}, 32'h0);
      haddr = 16'h004;
      @(negedge clk);
      chk("b2b_win_ready", {31'b0, hready}, 32'h1);
      chk("b2b_win_data", hrdata, 32'hBBBB_AAAA);
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00;
      chk("b2b_stat_ready", {31'b0, hready}, 32'h1);
      chk("b2b_stat_data", hrdata, 32'h6);

      @(negedge clk); done_b = 1'b1;
      repeat (2) @(negedge clk);
      done_b = 1'b0;
      run_range(20, 25);
      use_b = 1'b0;

      // reset asserted during a window-read wait state
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = SZW; haddr = 16'h100;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      chk("midwait_pre_ready", {31'b0, hreadyout_a}, 32'h0);
      hresetn = 1'b0;
      #1;
      chk("midwait_rst_ready", {31'b0, hreadyout_a}, 32'h1);
      chk("midwait_rst_resp", {31'b0, hresp_a}, 32'h0);
      chk("midwait_rst_rdata", hrdata_a, 32'h0);
      chk("midwait_rst_core_reset", {31'b0, core_reset_a}, 32'h1);
      repeat (2) @(negedge clk);
      hresetn = 1'b1;

      run_range(26, 35);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
